uart_rx_word: RTL and testbench

Receive-side front end of the UART link. It samples the asynchronous `uart_rxd` line, recovers 8N1 bytes at `UART_BPS`, and packs each group of `DATA_WIDTH/8` bytes little-endian into one word. Each word goes out on a valid/ready handshake to the receive FIFO inside the UART top level. It runs in the 200 MHz system clock domain produced by the differential clock buffer.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_word_if.sv | 11 +
 rtl/uart_rx_byte.sv | 91 +++++++++
 rtl/uart_rx_word.sv | 99 +++++++++
 tb/tb_uart_rx_word.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic int baud_div(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Valid/ready word channel from the UART receiver to the receive FIFO.
interface uart_rx_word_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, start-edge detect and mid-bit sampling FSM.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 20,
    parameter int HALF_DIV = 10
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       line_idle
);
    localparam int TW = $clog2(BAUD_DIV + 1);

    logic          rxd_m, rxd_s, rxd_d;
    logic          fall;
    uart_state_e   state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign fall      = rxd_d & ~rxd_s;
    assign line_idle = (state == IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            rxd_d      <= 1'b1;
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxd_m      <= uart_rxd;
            rxd_s      <= rxd_m;
            rxd_d      <= rxd_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        timer <= '0;
                    end
                end
                START: begin
                    if (timer == TW'(HALF_DIV - 1)) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == TW'(BAUD_DIV - 1)) begin
                        timer   <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == TW'(BAUD_DIV - 1)) begin
                        timer <= '0;
                        state <= IDLE;
                        if (rxd_s) begin
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_word.sv
// UART receive front end: packs 8N1 bytes little-endian into words on a valid/ready channel.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 200000000,
    parameter int UART_BPS     = 9600,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           uart_rxd,
    uart_rx_word_if.master word_if,
    output logic           frame_err,
    output logic           overrun,
    output logic           timeout
);
    localparam int BAUD_DIV  = baud_div(CLK_FREQ, UART_BPS);
    localparam int HALF_DIV  = BAUD_DIV / 2;
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int TO_CYCLES = TIMEOUT_BITS * BAUD_DIV;
    localparam int CW        = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TOW       = $clog2(TO_CYCLES + 1);

    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("uart_rx_word: DATA_WIDTH must be a positive multiple of 8");
    end

    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  line_idle;
    logic [DATA_WIDTH-1:0] asm_q, asm_next;
    logic [CW-1:0]         cnt;
    logic [TOW-1:0]        idle_cnt;
    logic                  last_lane, take;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV),
        .HALF_DIV (HALF_DIV)
    ) u_byte (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_rxd   (uart_rxd),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .line_idle  (line_idle)
    );

    assign last_lane = (cnt == CW'(BYTES - 1));
    assign take      = word_if.word_valid & word_if.word_ready;

    always_comb begin
        asm_next               = asm_q;
        asm_next[8*cnt +: 8]   = byte_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            asm_q              <= '0;
            cnt                <= '0;
            idle_cnt           <= '0;
            word_if.word_data  <= '0;
            word_if.word_valid <= 1'b0;
            overrun            <= 1'b0;
            timeout            <= 1'b0;
        end else begin
            overrun <= 1'b0;
            timeout <= 1'b0;
            if (take) word_if.word_valid <= 1'b0;

            // Partial word ages out only while the line sits idle.
            if (!line_idle || cnt == '0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TOW'(TO_CYCLES - 1)) begin
                idle_cnt <= '0;
                cnt      <= '0;
                timeout  <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (byte_valid) begin
                if (last_lane) begin
                    cnt <= '0;
                    if (!word_if.word_valid || take) begin
                        word_if.word_data  <= asm_next;
                        word_if.word_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    asm_q <= asm_next;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at BAUD_DIV=20, DATA_WIDTH=32.
module tb_uart_rx_word;
    localparam int BAUD = 20;
    // Pin-to-word_valid latency from start-bit drive: 3 detect + 10 half + 180 bits + 1 load.
    localparam int LAT  = 194;

    logic sys_clk  = 1'b0;
    logic sys_rst  = 1'b1;
    logic uart_rxd = 1'b1;
    logic frame_err, overrun, timeout;

    uart_rx_word_if #(.DATA_WIDTH(32)) wif ();

    uart_rx_word #(
        .CLK_FREQ     (200000000),
        .UART_BPS     (10000000),
        .DATA_WIDTH   (32),
        .TIMEOUT_BITS (20)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_rxd  (uart_rxd),
        .word_if   (wif),
        .frame_err (frame_err),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int          n_valid = 0, n_ferr = 0, n_ovr = 0, n_to = 0;
    int          rise_cyc = -1, to_cyc = -1;
    logic [31:0] rise_data = '0;
    logic        prev_valid = 1'b0;
    always @(negedge sys_clk) begin
        if (wif.word_valid) n_valid++;
        if (wif.word_valid && !prev_valid) begin
            rise_cyc  = cyc;
            rise_data = wif.word_data;
        end
        prev_valid = wif.word_valid;
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (BAUD) @(posedge sys_clk);
        #1;
    endtask

    int last_start = 0;
    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = cyc;
        uart_rxd = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_bit();
        end
        uart_rxd = stop;
        wait_bit();
        if (stop) uart_rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    typedef struct {
        logic [0:3][7:0] b;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int v0, f0, o0, t0, s;

        vecs[0].b = {8'h11, 8'h22, 8'h33, 8'h44}; vecs[0].exp = 32'h44332211;
        vecs[1].b = {8'h00, 8'hFF, 8'hA5, 8'h5A}; vecs[1].exp = 32'h5AA5FF00;
        vecs[2].b = {8'h80, 8'h01, 8'h7E, 8'hC3}; vecs[2].exp = 32'hC37E0180;

        wif.word_ready = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check("rst_data", wif.word_data, 32'h0);
        check("rst_valid", {31'b0, wif.word_valid}, 32'h0);
        check("rst_flags", {29'b0, frame_err, overrun, timeout}, 32'h0);
        idle(10);

        // Back-to-back 4-byte words with the consumer always ready.
        for (int i = 0; i < 3; i++) begin
            v0 = n_valid;
            for (int j = 0; j < 4; j++) send_byte(vecs[i].b[j], 1'b1);
            idle(20);
            check($sformatf("vec%0d_data", i), rise_data, vecs[i].exp);
            check($sformatf("vec%0d_valid_cycles", i), n_valid - v0, 1);
            check($sformatf("vec%0d_latency", i), rise_cyc - last_start, LAT);
        end

        // Consumer stalled: second word overruns and is dropped.
        wif.word_ready = 1'b0;
        o0 = n_ovr;
        for (int j = 1; j <= 8; j++) send_byte(8'(j), 1'b1);
        idle(20);
        check("ovr_data", wif.word_data, 32'h04030201);
        check("ovr_valid_held", {31'b0, wif.word_valid}, 32'h1);
        check("ovr_pulses", n_ovr - o0, 1);
        wif.word_ready = 1'b1;
        @(negedge sys_clk);
        check("ovr_valid_before_edge", {31'b0, wif.word_valid}, 32'h1);
        @(negedge sys_clk);
        check("ovr_valid_fell", {31'b0, wif.word_valid}, 32'h0);
        check("ovr_data_kept", wif.word_data, 32'h04030201);
        @(posedge sys_clk);
        #1;
        idle(10);

        // Bad stop bit on byte 2; line held low afterwards must not re-trigger.
        f0 = n_ferr;
        v0 = n_valid;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        idle(60);
        uart_rxd = 1'b1;
        wait_bit();
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        send_byte(8'hEE, 1'b1);
        idle(20);
        check("ferr_pulses", n_ferr - f0, 1);
        check("ferr_word", rise_data, 32'hEEDDCCAA);
        check("ferr_valid_cycles", n_valid - v0, 1);

        // 5-cycle low glitch on an idle line.
        v0 = n_valid; f0 = n_ferr; o0 = n_ovr; t0 = n_to;
        uart_rxd = 1'b0;
        idle(5);
        uart_rxd = 1'b1;
        idle(300);
        check("glitch_flags", (n_valid - v0) + (n_ferr - f0) + (n_ovr - o0) + (n_to - t0), 0);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(20);
        check("glitch_next_word", rise_data, 32'hEFBEADDE);
        check("glitch_next_latency", rise_cyc - last_start, LAT);

        // Partial word times out after 400 idle cycles.
        t0 = n_to;
        v0 = n_valid;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        s = last_start;
        idle(420);
        check("to_pulses", n_to - t0, 1);
        // Line goes idle at the stop sample (s+193); pulse lands ~400 cycles later.
        check("to_timing", ((to_cyc - (s + 193)) >= 398 && (to_cyc - (s + 193)) <= 402) ? 1 : 0, 1);
        check("to_no_word", n_valid - v0, 0);
        for (int j = 1; j <= 4; j++) send_byte(8'(j), 1'b1);
        idle(20);
        check("to_next_word", rise_data, 32'h04030201);

        // Reset mid-byte 3 with a word still pending.
        wif.word_ready = 1'b0;
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h40, 1'b1);
        idle(10);
        check("rst2_pending", {31'b0, wif.word_valid}, 32'h1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h60, 1'b1);
        uart_rxd = 1'b0;
        wait_bit();
        wait_bit();
        idle(7);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst  = 1'b0;
        uart_rxd = 1'b1;
        check("rst2_data", wif.word_data, 32'h0);
        check("rst2_valid", {31'b0, wif.word_valid}, 32'h0);
        check("rst2_flags", {29'b0, frame_err, overrun, timeout}, 32'h0);
        wif.word_ready = 1'b1;
        idle(40);
        v0 = n_valid;
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h0C, 1'b1);
        send_byte(8'h0D, 1'b1);
        idle(20);
        check("rst2_next_word", rise_data, 32'h0D0C0B0A);
        check("rst2_valid_cycles", n_valid - v0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
